// File: rtl/switch_box.sv
// switch_box: FPGA routing switch box with disjoint topology.
//
// Four channels (left, up, right, down) of W bidirectional tracks each meet
// here. Track i on any side can connect only to track i on the other three
// sides through six directional pass switches per track. Each switch has
// two control bits in the configuration register.
//
// Ports:
//   clk      - configuration register clock
//   reset    - synchronous, active-high; clears the configuration register
//   left     - W-bit bidirectional left-side routing tracks
//   up       - W-bit bidirectional up-side routing tracks
//   right    - W-bit bidirectional right-side routing tracks
//   down     - W-bit bidirectional down-side routing tracks
//   inp_sram - 12*W-bit switch configuration word, registered into cfg_q
//   cfg_err  - (only with SWITCH_BOX_ERR_EN) registered flag; it is high when
//              the previous cfg_q made two or more enabled switches target
//              one pin
//
// Switch k = pair*W + track: enable = cfg_q[2k], dir = cfg_q[2k+1].
// Pairs: 0 L-U, 1 L-R, 2 L-D, 3 U-R, 4 U-D, 5 R-D. dir=0 means the side
// named first drives the other side. When several enabled switches target
// one pin, the switch with the lowest pair index drives that pin.
//
// Optional feature macro: SWITCH_BOX_ERR_EN (adds the cfg_err output).

module switch_box #(
  parameter int unsigned W = 5
) (
  input  logic            clk,
  input  logic            reset,
  inout  logic [W-1:0]    left,
  inout  logic [W-1:0]    up,
  inout  logic [W-1:0]    right,
  inout  logic [W-1:0]    down,
  input  logic [12*W-1:0] inp_sram
`ifdef SWITCH_BOX_ERR_EN
  ,
  output logic            cfg_err
`endif
);

  // Side encoding used for the per-track pin vector: 0 L, 1 U, 2 R, 3 D.
  localparam logic [1:0] SIDE_A [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
  localparam logic [1:0] SIDE_B [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3};

  logic [12*W-1:0] cfg_d;
  logic [12*W-1:0] cfg_q;

  always_comb begin
    cfg_d = inp_sram;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= '0;
    end else begin
      cfg_q <= cfg_d;
    end
  end

`ifdef SWITCH_BOX_ERR_EN
  logic [W-1:0] trk_conf;
  logic         err_d;
  logic         err_q;

  always_comb begin
    err_d = |trk_conf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign cfg_err = err_q;
`endif

  for (genvar i = 0; i < W; i++) begin : g_trk
    logic [5:0] en;
    logic [5:0] dir;
    logic [3:0] pin;
    logic [3:0] oe;
    logic [3:0] val;
`ifdef SWITCH_BOX_ERR_EN
    logic       conf;
`endif

    for (genvar p = 0; p < 6; p++) begin : g_pair
      assign en[p]  = cfg_q[2*(p*W+i)];
      assign dir[p] = cfg_q[2*(p*W+i)+1];
    end

    assign pin = {down[i], right[i], up[i], left[i]};

    // Pairs are visited in ascending order and a pin, once claimed, is not
    // re-driven, which gives the lowest pair index priority on that pin.
    always_comb begin
      logic [2:0] pi;
      logic [1:0] tgt;
      logic [1:0] src;
      oe  = '0;
      val = '0;
      pi  = '0;
      tgt = '0;
      src = '0;
`ifdef SWITCH_BOX_ERR_EN
      conf = 1'b0;
`endif
      for (int unsigned p = 0; p < 6; p++) begin
        pi  = 3'(p);
        tgt = dir[pi] ? SIDE_A[pi] : SIDE_B[pi];
        src = dir[pi] ? SIDE_B[pi] : SIDE_A[pi];
        if (en[pi]) begin
          if (!oe[tgt]) begin
            oe[tgt]  = 1'b1;
            val[tgt] = pin[src];
          end
`ifdef SWITCH_BOX_ERR_EN
          else begin
            conf = 1'b1;
          end
`endif
        end
      end
    end

`ifdef SWITCH_BOX_ERR_EN
    assign trk_conf[i] = conf;
`endif

    assign left[i]  = oe[0] ? val[0] : 1'bz;
    assign up[i]    = oe[1] ? val[1] : 1'bz;
    assign right[i] = oe[2] ? val[2] : 1'bz;
    assign down[i]  = oe[3] ? val[3] : 1'bz;
  end

endmodule

// File: tb/tb_switch_box.sv
// tb_switch_box: directed self-checking bench for switch_box (W = 5).
// The four buses are pulled up, so a pin nobody drives reads as 1; pins
// that the DUT must drive are checked with 0 on their source so that a
// released pin cannot be mistaken for a driven one.

module tb_switch_box;

  localparam int unsigned W = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [12*W-1:0] inp_sram;

  tri1 [W-1:0] left;
  tri1 [W-1:0] up;
  tri1 [W-1:0] right;
  tri1 [W-1:0] down;

  logic [W-1:0] l_drv, l_oe, u_drv, u_oe, r_drv, r_oe, d_drv, d_oe;

  for (genvar i = 0; i < W; i++) begin : g_bus
    assign left[i]  = l_oe[i] ? l_drv[i] : 1'bz;
    assign up[i]    = u_oe[i] ? u_drv[i] : 1'bz;
    assign right[i] = r_oe[i] ? r_drv[i] : 1'bz;
    assign down[i]  = d_oe[i] ? d_drv[i] : 1'bz;
  end

`ifdef SWITCH_BOX_ERR_EN
  logic cfg_err;
`endif

  switch_box #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .left     (left),
    .up       (up),
    .right    (right),
    .down     (down),
    .inp_sram (inp_sram)
`ifdef SWITCH_BOX_ERR_EN
    ,
    .cfg_err  (cfg_err)
`endif
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    l_oe = '0; u_oe = '0; r_oe = '0; d_oe = '0;
    l_drv = '0; u_drv = '0; r_drv = '0; d_drv = '0;
  endtask

  task automatic clear_cfg();
    release_all();
    inp_sram = '0;
    clk_edge();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inp_sram = '0;
    l_oe = 5'b00100; l_drv = 5'b00000;
    u_oe = 5'b11011; u_drv = 5'b01011;
    clk_edge();
    tests_run++; if (right !== 5'b11111) begin tests_failed++; $display("FAIL reset_right: got %b expected %b", right, 5'b11111); end
    tests_run++; if (down !== 5'b11111) begin tests_failed++; $display("FAIL reset_down: got %b expected %b", down, 5'b11111); end
    tests_run++; if (left !== 5'b11011) begin tests_failed++; $display("FAIL reset_left: got %b expected %b", left, 5'b11011); end
    tests_run++; if (up !== 5'b01111) begin tests_failed++; $display("FAIL reset_up: got %b expected %b", up, 5'b01111); end
`ifdef SWITCH_BOX_ERR_EN
    tests_run++; if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected %b", cfg_err, 1'b0); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_lu();
    logic [12*W-1:0] cfg;
    clear_cfg();
    l_oe = 5'b11111; l_drv = 5'b10001;
    cfg = '0; cfg[0] = 1'b1; cfg[4] = 1'b1; cfg[8] = 1'b1;
    inp_sram = cfg;
    #1;
    tests_run++; if (up !== 5'b11111) begin tests_failed++; $display("FAIL lu_latency: got %b expected %b", up, 5'b11111); end
    clk_edge();
    tests_run++; if (up !== 5'b11011) begin tests_failed++; $display("FAIL lu_vec1: got %b expected %b", up, 5'b11011); end
    l_drv = 5'b00000;
    #1;
    tests_run++; if (up !== 5'b01010) begin tests_failed++; $display("FAIL lu_vec2: got %b expected %b", up, 5'b01010); end
    tests_run++; if (right !== 5'b11111) begin tests_failed++; $display("FAIL lu_right: got %b expected %b", right, 5'b11111); end
    tests_run++; if (down !== 5'b11111) begin tests_failed++; $display("FAIL lu_down: got %b expected %b", down, 5'b11111); end
  endtask

  // Continues from test_lu: L-U on tracks 0,2,4 with left driven to 0.
  task automatic test_dir();
    logic [12*W-1:0] cfg;
    l_oe[0] = 1'b0;
    cfg = '0; cfg[0] = 1'b1; cfg[1] = 1'b1; cfg[4] = 1'b1; cfg[8] = 1'b1;
    inp_sram = cfg;
    clk_edge();
    u_oe[0] = 1'b1; u_drv[0] = 1'b0;
    #1;
    tests_run++; if (left[0] !== 1'b0) begin tests_failed++; $display("FAIL dir_ul_0: got %b expected %b", left[0], 1'b0); end
    u_drv[0] = 1'b1;
    #1;
    tests_run++; if (left[0] !== 1'b1) begin tests_failed++; $display("FAIL dir_ul_1: got %b expected %b", left[0], 1'b1); end
    u_drv[0] = 1'b0;
    cfg[0] = 1'b0;
    inp_sram = cfg;
    #1;
    tests_run++; if (left[0] !== 1'b0) begin tests_failed++; $display("FAIL dir_latency: got %b expected %b", left[0], 1'b0); end
    clk_edge();
    tests_run++; if (left[0] !== 1'b1) begin tests_failed++; $display("FAIL dir_release: got %b expected %b", left[0], 1'b1); end
    tests_run++; if (up[2] !== 1'b0) begin tests_failed++; $display("FAIL dir_keep_up2: got %b expected %b", up[2], 1'b0); end
  endtask

  task automatic test_lr();
    logic [12*W-1:0] cfg;
    clear_cfg();
    l_oe = 5'b11111; l_drv = 5'b11101;
    cfg = '0; cfg[12] = 1'b1; cfg[16] = 1'b1;
    inp_sram = cfg;
    clk_edge();
    tests_run++; if (right !== 5'b11101) begin tests_failed++; $display("FAIL lr_vec1: got %b expected %b", right, 5'b11101); end
    tests_run++; if (down !== 5'b11111) begin tests_failed++; $display("FAIL lr_down: got %b expected %b", down, 5'b11111); end
    tests_run++; if (up !== 5'b11111) begin tests_failed++; $display("FAIL lr_up: got %b expected %b", up, 5'b11111); end
    l_drv = 5'b00100;
    #1;
    tests_run++; if (right !== 5'b10101) begin tests_failed++; $display("FAIL lr_vec2: got %b expected %b", right, 5'b10101); end
  endtask

  task automatic test_priority();
    logic [12*W-1:0] cfg;
    clear_cfg();
    l_oe[1] = 1'b1; l_drv[1] = 1'b0;
    r_oe[1] = 1'b1; r_drv[1] = 1'b1;
    cfg = '0; cfg[22] = 1'b1; cfg[52] = 1'b1;
    inp_sram = cfg;
    clk_edge();
    tests_run++; if (down !== 5'b11101) begin tests_failed++; $display("FAIL prio_vec1: got %b expected %b", down, 5'b11101); end
`ifdef SWITCH_BOX_ERR_EN
    tests_run++; if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL prio_err_early: got %b expected %b", cfg_err, 1'b0); end
`endif
    l_drv[1] = 1'b1; r_drv[1] = 1'b0;
    #1;
    tests_run++; if (down[1] !== 1'b1) begin tests_failed++; $display("FAIL prio_vec2: got %b expected %b", down[1], 1'b1); end
    clk_edge();
`ifdef SWITCH_BOX_ERR_EN
    tests_run++; if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL prio_err_set: got %b expected %b", cfg_err, 1'b1); end
`endif
    cfg[52] = 1'b0;
    inp_sram = cfg;
    l_drv[1] = 1'b0;
    clk_edge();
    tests_run++; if (down[1] !== 1'b0) begin tests_failed++; $display("FAIL prio_single: got %b expected %b", down[1], 1'b0); end
`ifdef SWITCH_BOX_ERR_EN
    tests_run++; if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL prio_err_hold: got %b expected %b", cfg_err, 1'b1); end
`endif
    clk_edge();
`ifdef SWITCH_BOX_ERR_EN
    tests_run++; if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL prio_err_clear: got %b expected %b", cfg_err, 1'b0); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [12*W-1:0] cfg;
    clear_cfg();
    l_oe = 5'b11111; l_drv = 5'b00000;
    cfg = '0; cfg[12] = 1'b1; cfg[16] = 1'b1;
    inp_sram = cfg;
    clk_edge();
    tests_run++; if (right !== 5'b10101) begin tests_failed++; $display("FAIL rmid_before: got %b expected %b", right, 5'b10101); end
    reset = 1'b1;
    #1;
    tests_run++; if (right !== 5'b10101) begin tests_failed++; $display("FAIL rmid_pre_edge: got %b expected %b", right, 5'b10101); end
    clk_edge();
    tests_run++; if (right !== 5'b11111) begin tests_failed++; $display("FAIL rmid_released: got %b expected %b", right, 5'b11111); end
    reset = 1'b0;
    clk_edge();
    tests_run++; if (right !== 5'b10101) begin tests_failed++; $display("FAIL rmid_restored: got %b expected %b", right, 5'b10101); end
  endtask

  task automatic test_back_to_back();
    logic [12*W-1:0] cfg;
    clear_cfg();
    l_oe = 5'b00001; l_drv = 5'b00000;
    cfg = '0; cfg[0] = 1'b1;
    inp_sram = cfg;
    clk_edge();
    tests_run++; if (up !== 5'b11110) begin tests_failed++; $display("FAIL b2b_lu_up: got %b expected %b", up, 5'b11110); end
    tests_run++; if (right !== 5'b11111) begin tests_failed++; $display("FAIL b2b_lu_right: got %b expected %b", right, 5'b11111); end
    cfg = '0; cfg[10] = 1'b1;
    inp_sram = cfg;
    clk_edge();
    tests_run++; if (up !== 5'b11111) begin tests_failed++; $display("FAIL b2b_lr_up: got %b expected %b", up, 5'b11111); end
    tests_run++; if (right !== 5'b11110) begin tests_failed++; $display("FAIL b2b_lr_right: got %b expected %b", right, 5'b11110); end
    inp_sram = '0;
    clk_edge();
    tests_run++; if (right !== 5'b11111) begin tests_failed++; $display("FAIL b2b_off_right: got %b expected %b", right, 5'b11111); end
  endtask

  initial begin
    reset = 1'b1;
    inp_sram = '0;
    release_all();
    test_reset();
    test_lu();
    test_dir();
    test_lr();
    test_priority();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
